matriz_serializador: RTL and testbench

Drains a 200-bit packed 5x5 matrix of 8-bit elements, as produced by the ULA operation units, into a stream of single elements for write-back to the matrix memory. On start it captures the matrix and the active size into a shadow register, then emits only the elements inside the active NxN window. Emission is row-major over a valid/ready handshake. It is the producer-side counterpart of the ULA's packed-matrix inputs: the ULA consumes whole 200-bit matrices, and this block unpacks results element by element.

---
 rtl/matriz_serializador.sv | 113 +++++++++++
 tb/tb_matriz_serializador.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/matriz_serializador.sv
// Streams the active NxN window of a packed 5x5 matrix as single elements,
// row-major, over a valid/ready handshake for write-back to matrix memory.
module matriz_serializador #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned DIM    = 5,
    parameter int unsigned IDX_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                tamanho,
    input  logic [DIM*DIM*ELEM_W-1:0] matriz_in,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELEM_W-1:0]         out_dado,
    output logic [IDX_W-1:0]          out_endereco,
    output logic                      out_ultimo,
    output logic                      done
);

    localparam int unsigned MAT_W = DIM * DIM * ELEM_W;
    localparam int unsigned CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned SEL_W = $clog2(MAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [MAT_W-1:0]   shadowMat;
    logic [1:0]         tamQ;
    logic [CNT_W-1:0]   row;
    logic [CNT_W-1:0]   col;

    logic [CNT_W-1:0]   lastIdx;
    logic               lastRow;
    logic               lastCol;
    logic               handshake;
    logic [IDX_W-1:0]   linIdx;
    logic [SEL_W-1:0]   bitSel;

    // Window edge is N-1 = tamanho+1 on the captured size.
    assign lastIdx   = CNT_W'(tamQ) + CNT_W'(1);
    assign lastRow   = (row == lastIdx);
    assign lastCol   = (col == lastIdx);
    assign handshake = out_valid & out_ready;

    // Address uses the full 5-wide memory layout, not a compacted window index.
    assign linIdx       = IDX_W'(row) * IDX_W'(DIM) + IDX_W'(col);
    assign bitSel       = SEL_W'(linIdx) * SEL_W'(ELEM_W);
    assign out_endereco = linIdx;
    assign out_dado     = shadowMat[bitSel +: ELEM_W];
    assign out_ultimo   = out_valid & lastRow & lastCol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            shadowMat <= '0;
            tamQ      <= 2'b00;
            row       <= '0;
            col       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        shadowMat <= matriz_in;
                        tamQ      <= tamanho;
                        row       <= '0;
                        col       <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (lastRow && lastCol) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (lastCol) begin
                            col <= '0;
                            row <= row + CNT_W'(1);
                        end else begin
                            col <= col + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matriz_serializador.sv
// Directed bench for matriz_serializador: window sizes, backpressure,
// input isolation, ignored start, mid-stream reset and back-to-back runs.
module tb_matriz_serializador;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   tamanho;
    logic [199:0] matriz_in;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_dado;
    logic [4:0]   out_endereco;
    logic         out_ultimo;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic [199:0] baseMat;

    matriz_serializador dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .tamanho      (tamanho),
        .matriz_in    (matriz_in),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dado     (out_dado),
        .out_endereco (out_endereco),
        .out_ultimo   (out_ultimo),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at an idle negedge; returns at the negedge showing the first beat.
    task automatic kickoff(input logic [1:0] tam);
        tamanho = tam;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Checks a whole run from its first beat through done and the idle cycle after.
    task automatic expectStream(input logic [1:0] tam, input bit ff,
                                input int stallAddr, input int disturbBeat);
        int n;
        int beat;
        int a;
        logic [7:0] d;
        n    = int'(tam) + 2;
        beat = 0;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                a = r * 5 + c;
                d = ff ? 8'hFF : 8'(a + 1);
                chk("beat_valid", 32'(out_valid), 32'd1);
                chk("beat_addr", 32'(out_endereco), 32'(a));
                chk("beat_dado", 32'(out_dado), 32'(d));
                chk("beat_ultimo", 32'(out_ultimo), 32'((r == n - 1) && (c == n - 1)));
                chk("beat_busy", 32'(busy), 32'd1);
                chk("beat_done", 32'(done), 32'd0);
                if (disturbBeat >= 0 && beat == disturbBeat) begin
                    matriz_in = {25{8'hFF}};
                    tamanho   = 2'b11;
                    start     = 1'b1;
                end else if (disturbBeat >= 0 && beat == disturbBeat + 1) begin
                    start = 1'b0;
                end
                if (a == stallAddr) begin
                    out_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        chk("stall_valid", 32'(out_valid), 32'd1);
                        chk("stall_addr", 32'(out_endereco), 32'(a));
                        chk("stall_dado", 32'(out_dado), 32'(d));
                        chk("stall_ultimo", 32'(out_ultimo), 32'd0);
                    end
                    out_ready = 1'b1;
                end
                beat++;
                @(negedge clk);
            end
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_ultimo", 32'(out_ultimo), 32'd0);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 25; i++) baseMat[i*8 +: 8] = 8'(i + 1);
        rst_n     = 1'b0;
        start     = 1'b0;
        tamanho   = 2'b00;
        out_ready = 1'b1;
        matriz_in = baseMat;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ultimo", 32'(out_ultimo), 32'd0);
        chk("rst_dado", 32'(out_dado), 32'd0);
        chk("rst_addr", 32'(out_endereco), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 5x5 with ready held high
        kickoff(2'b11);
        expectStream(2'b11, 1'b0, -1, -1);

        // 2x2 window
        kickoff(2'b00);
        expectStream(2'b00, 1'b0, -1, -1);

        // 3x3 with a 3-cycle stall on address 5
        kickoff(2'b01);
        expectStream(2'b01, 1'b0, 5, -1);

        // 4x4: input change and start pulse mid-run are ignored
        kickoff(2'b10);
        expectStream(2'b10, 1'b0, -1, 3);
        kickoff(2'b10);
        expectStream(2'b10, 1'b1, -1, -1);

        // Reset at beat 10 of a 5x5 run
        matriz_in = baseMat;
        kickoff(2'b11);
        for (int i = 0; i < 10; i++) begin
            chk("pre_rst_addr", 32'(out_endereco), 32'(i));
            chk("pre_rst_dado", 32'(out_dado), 32'(i + 1));
            @(negedge clk);
        end
        chk("pre_rst_addr10", 32'(out_endereco), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr", 32'(out_endereco), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end
        kickoff(2'b11);
        expectStream(2'b11, 1'b0, -1, -1);

        // start held high: back-to-back 2x2 runs with one idle cycle between
        tamanho = 2'b00;
        start   = 1'b1;
        @(negedge clk);
        expectStream(2'b00, 1'b0, -1, -1);
        @(negedge clk);
        expectStream(2'b00, 1'b0, -1, -1);
        start = 1'b0;
        @(negedge clk);
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
